// File: rtl/imm_decode_stage.sv
// RV immediate decode stage: classifies the instruction format, builds the
// XLEN-wide immediate, and queues {imm, fmt, pc} in a small in-order buffer.
module imm_decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc
);

  if (!((XLEN == 32 || XLEN == 64) && (DEPTH == 1 || DEPTH == 2))) begin : g_bad_param
    $error("imm_decode_stage: XLEN must be 32 or 64 and DEPTH must be 1 or 2");
  end

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6, F_ILL = 3'd7;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011, OP_32 = 7'b0111011;
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);
  localparam bit         RV32 = (XLEN == 32);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_sh;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [63:0]     imm_u64;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;

  assign opc     = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign is_sh   = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b   = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j   = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_u   = imm_u64[XLEN-1:0];
  // Only RV64 OP-IMM shifts use the 6-bit shamt; W-shifts stay 5-bit.
  assign imm_sh  = XLEN'({(opc == OP_IMM && !RV32) ? in_instr[25] : 1'b0, in_instr[24:20]});

  always_comb begin
    dec_fmt = F_ILL;
    unique case (opc)
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: dec_fmt = F_I;
      OP_IMM:   dec_fmt = !is_sh ? F_I : ((RV32 && in_instr[25]) ? F_ILL : F_SH);
      OP_IMM32: dec_fmt = RV32 ? F_ILL : (!is_sh ? F_I : (in_instr[25] ? F_ILL : F_SH));
      7'b0100011: dec_fmt = F_S;
      7'b1100011: dec_fmt = F_B;
      7'b0110111, 7'b0010111: dec_fmt = F_U;
      7'b1101111: dec_fmt = F_J;
      7'b0110011: dec_fmt = F_R;
      OP_32:    dec_fmt = RV32 ? F_ILL : F_R;
      default:  dec_fmt = F_ILL;
    endcase
  end

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      F_I:     dec_imm = imm_i;
      F_S:     dec_imm = imm_s;
      F_B:     dec_imm = imm_b;
      F_U:     dec_imm = imm_u;
      F_J:     dec_imm = imm_j;
      F_SH:    dec_imm = imm_sh;
      default: dec_imm = '0;
    endcase
  end

  // Buffer: entry 0 is always the head; pops shift toward it.
  entry_t     ent_q [DEPTH];
  entry_t     ent_d [DEPTH];
  entry_t     dec_ent;
  logic [1:0] cnt_q, cnt_d, wr_idx;
  logic       push, pop;

  assign in_ready  = (cnt_q < DEPTH_C);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_idx    = cnt_q - 2'(pop);
  assign dec_ent   = '{imm: dec_imm, fmt: dec_fmt, pc: in_pc};

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
        ent_d[DEPTH-1] = '0;
      end
      for (int i = 0; i < DEPTH; i++)
        if (push && 2'(i) == wr_idx) ent_d[i] = dec_ent;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign out_imm = ent_q[0].imm;
  assign out_fmt = ent_q[0].fmt;
  assign out_pc  = ent_q[0].pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an RV64/DEPTH=2 and an RV32/DEPTH=1
// instance share stimulus; decode table plus buffer flow-control sequences.
module tb_imm_decode_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        rdy64, vld64, rdy32, vld32;
  logic [63:0] imm64, pc64;
  logic [31:0] imm32, pc32;
  logic [2:0]  fmt64, fmt32;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_pc(pc64));

  imm_decode_stage #(.XLEN(32), .DEPTH(1)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_pc(pc32));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic [2:0]  f32;
    logic [31:0] i32;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [31:0] instr, logic [2:0] f64, logic [63:0] i64,
                              logic [2:0] f32, logic [31:0] i32);
    vec_t v;
    v.instr = instr; v.f64 = f64; v.i64 = i64; v.f32 = f32; v.i32 = i32;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " vld64"}, 64'(vld64), 64'd0);
    chk({nm, " rdy64"}, 64'(rdy64), 64'd1);
    chk({nm, " imm64"}, imm64, 64'd0);
    chk({nm, " fmt64"}, 64'(fmt64), 64'd0);
    chk({nm, " pc64"},  pc64, 64'd0);
    chk({nm, " vld32"}, 64'(vld32), 64'd0);
    chk({nm, " rdy32"}, 64'(rdy32), 64'd1);
    chk({nm, " imm32"}, 64'(imm32), 64'd0);
    chk({nm, " pc32"},  64'(pc32), 64'd0);
  endtask

  initial begin
    logic [63:0] pcv;
    logic [31:0] pcv32;

    vt.push_back(mk(32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF)); // addi -1
    vt.push_back(mk(32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 32'h80000000)); // lui
    vt.push_back(mk(32'h43F0D093, 3'd6, 64'h000000000000003F, 3'd7, 32'h00000000)); // srai 63
    // instr[7]=0 here, so imm[11]=0: offset is -2052, not -4.
    vt.push_back(mk(32'hFE000E63, 3'd3, 64'hFFFFFFFFFFFFF7FC, 3'd3, 32'hFFFFF7FC));
    vt.push_back(mk(32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 32'hFFFFFFFC)); // beq -4
    vt.push_back(mk(32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 32'hFFFFFFFC)); // sw -4
    vt.push_back(mk(32'h0080006F, 3'd5, 64'h0000000000000008, 3'd5, 32'h00000008)); // jal +8
    vt.push_back(mk(32'hFFDFF06F, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5, 32'hFFFFFFFC)); // jal -4
    vt.push_back(mk(32'h003100B3, 3'd0, 64'h0,                3'd0, 32'h0));        // add
    vt.push_back(mk(32'h003100BB, 3'd0, 64'h0,                3'd7, 32'h0));        // addw
    vt.push_back(mk(32'h00509093, 3'd6, 64'h0000000000000005, 3'd6, 32'h00000005)); // slli 5
    vt.push_back(mk(32'h02009093, 3'd6, 64'h0000000000000020, 3'd7, 32'h0));        // slli 32
    vt.push_back(mk(32'h0200909B, 3'd7, 64'h0,                3'd7, 32'h0));        // slliw 32
    vt.push_back(mk(32'h41F0D09B, 3'd6, 64'h000000000000001F, 3'd7, 32'h0));        // sraiw 31
    vt.push_back(mk(32'hFFF0809B, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd7, 32'h0));        // addiw -1
    vt.push_back(mk(32'h00000001, 3'd7, 64'h0,                3'd7, 32'h0));        // [1:0]!=11
    vt.push_back(mk(32'h0000007F, 3'd7, 64'h0,                3'd7, 32'h0));        // bad opcode
    vt.push_back(mk(32'h12345097, 3'd4, 64'h0000000012345000, 3'd4, 32'h12345000)); // auipc
    vt.push_back(mk(32'h7FF12083, 3'd1, 64'h00000000000007FF, 3'd1, 32'h000007FF)); // lw
    vt.push_back(mk(32'h800080E7, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1, 32'hFFFFF800)); // jalr
    vt.push_back(mk(32'h00000073, 3'd1, 64'h0,                3'd1, 32'h0));        // ecall
    vt.push_back(mk(32'h0FF0000F, 3'd1, 64'h00000000000000FF, 3'd1, 32'h000000FF)); // fence

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    reset = 1'b0;
    chk_reset_state("reset");

    // Decode table: one instruction at a time, pop on the following edge.
    out_ready = 1'b1;
    foreach (vt[i]) begin
      pcv   = 64'hABCD_0000_1000_0000 | 64'(i * 4);
      pcv32 = pcv[31:0];
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = pcv;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d vld64", i), 64'(vld64), 64'd1);
      chk($sformatf("v%0d fmt64", i), 64'(fmt64), 64'(vt[i].f64));
      chk($sformatf("v%0d imm64", i), imm64, vt[i].i64);
      chk($sformatf("v%0d pc64", i),  pc64, pcv);
      chk($sformatf("v%0d vld32", i), 64'(vld32), 64'd1);
      chk($sformatf("v%0d fmt32", i), 64'(fmt32), 64'(vt[i].f32));
      chk($sformatf("v%0d imm32", i), 64'(imm32), 64'(vt[i].i32));
      chk($sformatf("v%0d pc32", i),  64'(pc32), 64'(pcv32));
      step();
    end
    chk("table drained", 64'(vld64), 64'd0);

    // Backpressure: three inputs, two accepted, third held until drain.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h1000;
    chk("bp rdy empty", 64'(rdy64), 64'd1);
    step();
    chk("bp vld after A", 64'(vld64), 64'd1);
    chk("bp rdy occ1", 64'(rdy64), 64'd1);
    in_instr = 32'h800000B7; in_pc = 64'h1004;
    step();
    chk("bp rdy full", 64'(rdy64), 64'd0);
    in_instr = 32'h00509093; in_pc = 64'h1008;
    step();
    chk("bp rdy held", 64'(rdy64), 64'd0);
    chk("bp stable pc", pc64, 64'h1000);
    chk("bp stable imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("bp stable fmt", 64'(fmt64), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp head B pc", pc64, 64'h1004);
    chk("bp head B imm", imm64, 64'hFFFFFFFF80000000);
    chk("bp rdy after pop", 64'(rdy64), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp head C vld", 64'(vld64), 64'd1);
    chk("bp head C pc", pc64, 64'h1008);
    chk("bp head C imm", imm64, 64'h5);
    step();
    chk("bp drained", 64'(vld64), 64'd0);

    // Streaming at one per cycle with out_ready held high.
    for (int k = 0; k < 4; k++) begin
      logic [11:0] kimm;
      kimm = 12'(k + 1);
      in_valid = 1'b1; in_instr = {kimm, 5'd0, 3'b000, 5'd1, 7'h13};
      in_pc = 64'h2000 + 64'(k * 4);
      step();
      chk($sformatf("tp%0d vld", k), 64'(vld64), 64'd1);
      chk($sformatf("tp%0d rdy", k), 64'(rdy64), 64'd1);
      chk($sformatf("tp%0d pc", k),  pc64, 64'h2000 + 64'(k * 4));
      chk($sformatf("tp%0d imm", k), imm64, 64'(k + 1));
    end
    in_valid = 1'b0;
    step();
    chk("tp drained", 64'(vld64), 64'd0);

    // Flush at full occupancy drops the same-cycle input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h3000;
    step();
    in_pc = 64'h3004;
    step();
    chk("fl full", 64'(rdy64), 64'd0);
    flush = 1'b1; in_pc = 64'h3008;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl vld", 64'(vld64), 64'd0);
    chk("fl rdy", 64'(rdy64), 64'd1);
    step();
    chk("fl input dropped", 64'(vld64), 64'd0);

    // Reset mid-stream wins over flush and handshakes.
    in_valid = 1'b1; in_instr = 32'h800000B7; in_pc = 64'h4000;
    step();
    chk("rs occ1", 64'(vld64), 64'd1);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1; in_pc = 64'h4004;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_reset_state("midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
